// File: rtl/bcd_down_timer.sv
// Multi-digit packed-BCD countdown timer: load, start/pause/resume, one count per tick,
// and a single-cycle done pulse when the count reaches zero.
module bcd_down_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] dec_val;
  logic         borrow;
  logic         load_ok;

  // Borrow ripples up through zero digits, which wrap to 9; digits above stay put.
  always_comb begin
    borrow  = 1'b1;
    dec_val = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // Strict priority load > pause > start > tick; a start in RUN does not block a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      state    <= S_IDLE;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= S_IDLE;
        if (load_ok) begin
          count    <= load_val;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (pause) begin
        if (state == S_RUN) state <= S_PAUSED;
      end else begin
        if (start) begin
          if ((state == S_IDLE && count != '0) || state == S_PAUSED) state <= S_RUN;
        end
        if (tick && state == S_RUN) begin
          count <= dec_val;
          if (dec_val == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  assign busy = (state == S_RUN) || (state == S_PAUSED);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer: directed test-plan steps followed by a random
// phase, all compared against an integer-valued reference model of the countdown.
module tb_bcd_down_timer;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         load_err;

  int n_checks = 0;
  int n_pass   = 0;

  int m_val   = 0;
  int m_state = M_IDLE;
  bit m_done  = 0;
  bit m_err   = 0;

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count), .busy(busy), .done(done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic bit bcd_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference behaviour in terms of a decimal value and an abstract run state.
  task automatic modelStep(input bit l, input logic [W-1:0] lv, input bit s, input bit p,
                           input bit t);
    int old = m_state;
    m_done = 0;
    if (l) begin
      m_state = M_IDLE;
      if (bcd_ok(lv)) begin
        m_val = bcd2int(lv);
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (p) begin
      if (old == M_RUN) m_state = M_PAUSED;
    end else begin
      if (s && ((old == M_IDLE && m_val != 0) || old == M_PAUSED)) m_state = M_RUN;
      if (t && old == M_RUN) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_state = M_IDLE;
          m_done  = 1;
        end
      end
    end
  endtask

  task automatic modelReset();
    m_val = 0; m_state = M_IDLE; m_done = 0; m_err = 0;
  endtask

  task automatic checkOne(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".count"},    count,            int2bcd(m_val));
    checkOne({tag, ".busy"},     W'(busy),         W'(m_state != M_IDLE));
    checkOne({tag, ".done"},     W'(done),         W'(m_done));
    checkOne({tag, ".load_err"}, W'(load_err),     W'(m_err));
  endtask

  task automatic applyStimulus(input string tag, input bit l, input logic [W-1:0] lv,
                               input bit s, input bit p, input bit t);
    @(negedge clk);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    modelStep(l, lv, s, p, t);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, '0, 0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] rv;
    bit           rl, rs, rp, rt;

    $display("[TB] bcd_down_timer bench starting");
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    // Countdown from 12 with ticks spaced three clocks apart.
    applyStimulus("ld12", 1, 16'h0012, 0, 0, 0);
    applyStimulus("st12", 0, '0, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("cd12.tick", 0, '0, 0, 0, 1);
      idleCycles("cd12.gap", 2);
    end
    checkOne("cd12.final", count, 16'h0000);

    // Borrow chain across several zero digits.
    applyStimulus("ld1000", 1, 16'h1000, 0, 0, 0);
    applyStimulus("st1000", 0, '0, 1, 0, 0);
    applyStimulus("t1000a", 0, '0, 0, 0, 1);
    checkOne("borrow.0999", count, 16'h0999);
    applyStimulus("t1000b", 0, '0, 0, 0, 1);
    checkOne("borrow.0998", count, 16'h0998);

    // Invalid load keeps the count and sets the sticky error; a valid load clears it.
    applyStimulus("ldA5", 1, 16'h00A5, 0, 0, 0);
    checkOne("bad.err", W'(load_err), W'(1));
    idleCycles("bad.hold", 2);
    applyStimulus("ld05", 1, 16'h0005, 0, 0, 0);
    checkOne("good.count", count, 16'h0005);

    // Pause freezes the count; resume runs it to zero.
    applyStimulus("ld09", 1, 16'h0009, 0, 0, 0);
    applyStimulus("st09", 0, '0, 1, 0, 0);
    repeat (2) applyStimulus("t09", 0, '0, 0, 0, 1);
    applyStimulus("pz09", 0, '0, 0, 1, 0);
    repeat (5) applyStimulus("tpz", 0, '0, 0, 0, 1);
    checkOne("pause.hold", count, 16'h0007);
    applyStimulus("rs09", 0, '0, 1, 0, 0);
    repeat (7) applyStimulus("trs", 0, '0, 0, 0, 1);
    idleCycles("after.done", 2);

    // Start at zero, load beats start+tick, pause beats start.
    applyStimulus("st0", 0, '0, 1, 0, 0);
    applyStimulus("ldst", 1, 16'h0003, 1, 0, 1);
    checkOne("ldst.count", count, 16'h0003);
    applyStimulus("st3", 0, '0, 1, 0, 0);
    applyStimulus("pzst", 0, '0, 1, 1, 0);
    applyStimulus("pzst.tick", 0, '0, 0, 0, 1);

    // Asynchronous reset between edges while running at 0042.
    applyStimulus("ld43", 1, 16'h0043, 0, 0, 0);
    applyStimulus("st43", 0, '0, 1, 0, 0);
    applyStimulus("t43", 0, '0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async.rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) applyStimulus("post.rst", 0, '0, 0, 0, 1);

    // Random traffic with mostly small, mostly valid load values so countdowns finish.
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 15) == 0);
      rt = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 3))
        0:       rv = W'($urandom);
        1:       rv = int2bcd($urandom_range(0, 9999));
        default: rv = int2bcd($urandom_range(0, 25));
      endcase
      applyStimulus("rand", rl, rv, rs, rp, rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Multi-digit BCD down-counter/countdown timer, the decrementing counterpart of the team's BCD up-counter.
- Loaded with a packed BCD value, started, then decremented by one count per qualified tick until it reaches zero.
- On reaching zero it pulses done.
- Used for front-panel countdowns and timeouts that drive BCD displays directly.

Parameters:
- DIGITS, 4, number of BCD digits (>=1); count width is 4*DIGITS.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  load request, sampled each clk.
- load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
- start  input  1  start/resume request.
- pause  input  1  pause request.
- tick  input  1  single-cycle count enable (prescaler strobe).
- count  output  4*DIGITS  current packed BCD value (registered).
- busy  output  1  high in RUN or PAUSED.
- done  output  1  one-cycle pulse when the countdown reaches zero.
- load_err  output  1  sticky flag: last load carried an invalid BCD digit.

Behaviour:
- Reset (clock is clk; reset rst, asynchronous, active-high):
  - count=0, state=IDLE, busy=0, done=0, load_err=0.
  - Takes effect immediately, including mid-RUN; no done pulse is generated.
- States: IDLE, RUN, PAUSED. busy=1 in RUN or PAUSED (registered with the state).
- Priority per cycle: load > pause > start > tick.
- Load (any state):
  - Valid (every nibble <=9): count<=load_val, load_err<=0, state<=IDLE.
  - Invalid (any nibble >9): count unchanged, load_err<=1, state<=IDLE.
  - A load during RUN aborts the countdown without a done pulse.
- Start:
  - IDLE with count!=0: state<=RUN.
  - IDLE with count==0: ignored; no done pulse.
  - PAUSED: state<=RUN.
  - RUN: no effect.
- Pause:
  - RUN: state<=PAUSED.
  - Otherwise: ignored.
  - pause and start together in RUN or PAUSED: pause wins.
- Tick: honoured only in RUN and only when load and pause are low; ignored otherwise.
- Decrement (on an honoured tick, count updates at that same clk edge; latency 1):
  - Digit 0 decrements.
  - A digit at 0 that receives a borrow becomes 9 and propagates the borrow to the next digit.
  - Digits above the borrow chain are unchanged.
  - Example: 0x1000 -> 0x0999; 0x0010 -> 0x0009.
- Terminal count: if the decrement produces 0, state<=IDLE, busy<=0 and done<=1, all at the same edge count becomes 0.
  - done is high for exactly one cycle.
  - No wrap below zero is possible: RUN never holds count==0.
- count never holds a non-BCD nibble.
- load_err clears only on a valid load or reset.
- done=0 in every cycle other than the terminal-count cycle.
- Reset mid-operation: outputs return to reset values asynchronously; after release the block sits in IDLE and needs load+start.

Test Plan:
- Load 0x0012, start, 12 ticks spaced 3 clks -> count 0011,0010,0009,...,0001,0000; done=1 for exactly one clk coincident with first count=0000; busy falls same edge.
- Load 0x1000, start, one tick -> count=0x0999; second tick -> 0x0998; busy stays 1.
- Load 0x00A5 -> load_err=1, count unchanged, state IDLE; then load 0x0005 -> load_err=0, count=0x0005.
- Load 0x0009, start, 2 ticks (count 0x0007), pause, 5 ticks -> count stays 0x0007, busy=1; start, 7 ticks -> count 0x0000, done pulse.
- Start with count=0 -> busy stays 0, no done. Load 0x0003 with start and tick in the same cycle -> count=0x0003, state IDLE. Pause+start together in RUN -> PAUSED.
- RUN at 0x0042, assert rst asynchronously between edges -> count=0, busy=0, done=0 immediately; after release, ticks produce no change.
